irq_pending_ctrl: RTL

- Request-capture and issue stage that sits directly upstream of the 8:3 priority encoder.
- Latches rising edges on 8 request lines into a pending register and applies a mask.
- Selects the highest-priority unmasked pending request (bit 7 highest, bit 0 lowest) and presents its 3-bit index with a valid/ack handshake.
- Clears the serviced bit on acknowledge, then enforces a programmable dead time before the next issue.

---
 rtl/irq_pending_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Captures rising edges on the request lines into a sticky pending register.
// Issues the highest unmasked pending index over a valid/ack handshake.
// After each acknowledge, a programmable dead time passes before the next issue.
//
// state | meaning
// IDLE  | waiting for an eligible (pending & ~mask) request
// ISSUE | irq_id presented with irq_valid=1, held until irq_ack
// GAP   | dead time after an ack, no issue allowed
module irq_pending_ctrl #(
  parameter int NUM_REQ    = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         mask,
  input  logic                       clr,
  input  logic                       irq_ack,
  output logic                       irq_valid,
  output logic [$clog2(NUM_REQ)-1:0] irq_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       overflow
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [NUM_REQ-1:0]  req_q;
  logic [NUM_REQ-1:0]  rise;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  ack_clr;
  logic [ID_W-1:0]     sel_id;
  logic [3:0]          gap_cnt;
  logic                ack_fire;
  logic                issue;

  assign rise      = req & ~req_q;
  assign elig      = pending & ~mask;
  assign irq_valid = (state == ISSUE);
  assign ack_fire  = (state == ISSUE) & irq_ack;

  // Highest set bit of the eligible vector wins; later iterations override.
  always_comb begin
    sel_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (elig[i]) sel_id = ID_W'(i);
    end
  end

  // One-hot of the bit being serviced this cycle.
  always_comb begin
    ack_clr = '0;
    if (ack_fire) ack_clr[irq_id] = 1'b1;
  end

  // Request history for edge detection; keeps tracking through clr so held levels do not re-pend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= '0;
    else        req_q <= req;
  end

  // Pending capture: a new edge beats the ack clear on the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pending <= '0;
    else if (clr) pending <= '0;
    else          pending <= (pending & ~ack_clr) | rise;
  end

  // Sticky overflow: edge on a bit that is already pending and not being serviced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              overflow <= 1'b0;
    else if (clr)                            overflow <= 1'b0;
    else if (|(rise & pending & ~ack_clr))   overflow <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state; clr forces IDLE from any state.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (|elig) begin
          state_nxt = ISSUE;
          issue     = 1'b1;
        end
      end
      ISSUE: begin
        if (irq_ack) state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_cnt <= 4'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      issue     = 1'b0;
    end
  end

  // Issued index is captured once on entry to ISSUE and then held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     irq_id <= '0;
    else if (issue) irq_id <= sel_id;
  end

  // Dead-time down-counter loaded on ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               gap_cnt <= '0;
    else if (clr)                             gap_cnt <= '0;
    else if (ack_fire)                        gap_cnt <= 4'(GAP_CYCLES);
    else if (state == GAP && gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
  end

endmodule
